clr_sdp_ram: RTL and testbench
==============================

// Module: clr_sdp_ram
// PURPOSE
//  Parametrised simple-dual-port RAM (1 write, 1 read port) with registered read data and a
//  built-in sequential clear engine. Storage for the puzzle solver's state/node tables.
//  Clears one word per cycle instead of a single-cycle array reset, so it maps to block RAM.
//  Sits between the search controller and its node/state tables.
// PARAMETERS
//  DATA_W   17            word width in bits
//  ADDR_W   8             address width in bits
//  DEPTH    1<<ADDR_W     number of words; must satisfy DEPTH <= 2**ADDR_W
//  CLR_VAL  {DATA_W{1'b0}} value written to every word by a clear
// PORTS
//  clk      in   1       single clock; all logic on posedge
//  rst      in   1       synchronous, active-high reset
//  clr_req  in   1       start a full clear (pulse); ignored while busy
//  busy     out  1       clear in progress; ports are ignored while high
//  wr_en    in   1       write strobe
//  wr_addr  in   ADDR_W  write address
//  wr_data  in   DATA_W  write data
//  rd_en    in   1       read strobe
//  rd_addr  in   ADDR_W  read address
//  rd_data  out  DATA_W  registered read data; holds value between reads
//  rd_valid out  1       1-cycle pulse; rd_data is valid this cycle
//  err      out  1       1-cycle pulse: access dropped (busy) or address >= DEPTH
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=CLEAR, clr_ptr=0, busy=1, rd_data=0, rd_valid=0, err=0.
//    Array contents are not reset directly; the clear engine overwrites them.
//  - FSM states: IDLE, CLEAR.
//    CLEAR: each cycle mem[clr_ptr]<=CLR_VAL, clr_ptr++. Go to IDLE in the cycle that writes
//    DEPTH-1, so busy is high for exactly DEPTH cycles after reset deasserts.
//    IDLE: clr_req=1 -> CLEAR next cycle with clr_ptr=0.
//  - A write in IDLE commits at the posedge where wr_en=1. In the same cycle as clr_req, the write
//    is accepted; the clear then overwrites it.
//  - Read latency 1: rd_en=1 at edge N gives rd_data and rd_valid=1 after edge N+1.
//    rd_valid is 0 in every other cycle.
//  - Read and write to the same address in the same cycle: write-first.
//    rd_data returns the new wr_data.
//  - While busy:
//    * wr_en and rd_en are dropped; err pulses one cycle later; rd_valid stays 0.
//    * clr_req is ignored; the clear does not restart.
//  - Address >= DEPTH (only possible when DEPTH < 2**ADDR_W):
//    * A write is discarded.
//    * A read returns CLR_VAL with rd_valid=1.
//    * Either case pulses err.
//  - rst during CLEAR restarts the clear from 0. rst during an IDLE read suppresses that rd_valid.
//  - clr_ptr is $clog2(DEPTH) bits wide, with an explicit compare to DEPTH-1 (no reliance on wrap).
// STRUCTURE
//  - Shared package mem_pkg:
//    * state encoding localparams ST_IDLE=1'b0, ST_CLEAR=1'b1
//    * the default DATA_W and ADDR_W for solver tables
//  - Sub-module sdp_ram_core: bare array holding DEPTH words.
//    * one synchronous write port, one registered read port, no reset
//  - This module contains the FSM, clear pointer, write mux (clear vs user), write-first bypass,
//    address range checks, and the rd_valid and err registers.
// TESTING
//  1. Hold rst 2 cycles, then release (defaults) -> busy=1 for 256 cycles, then 0;
//     reading addr 0..255 returns 0.
//  2. Write 17'h1ABCD @0x05, then read 0x05 next cycle -> rd_data=17'h1ABCD with rd_valid
//     one cycle after rd_en.
//  3. Same cycle: wr_en @0x10 data 17'h00042 and rd_en @0x10 -> rd_data=17'h00042 (write-first).
//  4. Fill 0x00..0x03, pulse clr_req, then wr_en during busy:
//     * err pulses and nothing is written
//     * after 256 cycles, all reads return 0
//  5. DEPTH=200: write @8'd210, then read @8'd210 -> err pulses on both;
//     read returns CLR_VAL with rd_valid=1.
//  6. Assert rst at cycle 100 of a clear -> busy stays high 256 more cycles; no stale data survives.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the solver's node/state table memories.
package mem_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_CLEAR = 1'b1;

  localparam int SOLVER_DATA_W = 17;
  localparam int SOLVER_ADDR_W = 8;

endpackage

// File: rtl/sdp_ram_core.sv
// Bare simple-dual-port array: one synchronous write port, one registered read port, no reset.
module sdp_ram_core
  import mem_pkg::*;
#(
  parameter int DATA_W = SOLVER_DATA_W,
  parameter int ADDR_W = SOLVER_ADDR_W,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Read-before-write inside the array; the wrapper supplies write-first behaviour.
  always_ff @(posedge clk) begin
    if (re) q <= mem[rd_addr];
  end

endmodule

// File: rtl/clr_sdp_ram.sv
// Simple-dual-port RAM with registered reads, write-first bypass and a one-word-per-cycle
// clear engine, so the array itself never needs a reset and can map to block RAM.
module clr_sdp_ram
  import mem_pkg::*;
#(
  parameter int                DATA_W  = SOLVER_DATA_W,
  parameter int                ADDR_W  = SOLVER_ADDR_W,
  parameter int                DEPTH   = 1 << ADDR_W,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              err
);

  localparam int                PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic              state;
  logic              state_nxt;
  logic              idle;
  logic [PTR_W-1:0]  clr_ptr;
  logic              wr_ok;
  logic              rd_ok;
  logic              wr_acc;
  logic              rd_acc;
  logic              hit;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              hold_sel;
  logic [DATA_W-1:0] hold_data;
  logic [DATA_W-1:0] core_q;

  assign idle   = (state == ST_IDLE);
  assign wr_ok  = ({1'b0, wr_addr} < DEPTH_EXT);
  assign rd_ok  = ({1'b0, rd_addr} < DEPTH_EXT);
  assign wr_acc = idle && wr_en && wr_ok;
  assign rd_acc = idle && rd_en && rd_ok;
  assign hit    = wr_acc && rd_acc && (wr_addr == rd_addr);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_CLEAR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (clr_req) state_nxt = ST_CLEAR;
      ST_CLEAR: if (clr_ptr == LAST_PTR) state_nxt = ST_IDLE;
    endcase
  end

  // The clear engine owns the write port for the whole of CLEAR.
  always_comb begin
    busy     = (state == ST_CLEAR);
    mem_we   = wr_acc && !rst;
    mem_addr = wr_addr;
    mem_data = wr_data;
    if (state == ST_CLEAR) begin
      mem_we   = !rst;
      mem_addr = ADDR_W'(clr_ptr);
      mem_data = CLR_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_ptr <= '0;
    end else if (state == ST_CLEAR) begin
      if (clr_ptr == LAST_PTR) clr_ptr <= '0;
      else                     clr_ptr <= clr_ptr + 1'b1;
    end else begin
      clr_ptr <= '0;
    end
  end

  // rd_data comes either from the array register or from a held value covering reset,
  // same-address bypass and out-of-range reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid  <= 1'b0;
      err       <= 1'b0;
      hold_sel  <= 1'b1;
      hold_data <= '0;
    end else begin
      rd_valid <= idle && rd_en;
      err      <= idle ? ((wr_en && !wr_ok) || (rd_en && !rd_ok)) : (wr_en || rd_en);
      if (idle && rd_en) begin
        if (!rd_ok) begin
          hold_sel  <= 1'b1;
          hold_data <= CLR_VAL;
        end else if (hit) begin
          hold_sel  <= 1'b1;
          hold_data <= wr_data;
        end else begin
          hold_sel  <= 1'b0;
        end
      end
    end
  end

  assign rd_data = hold_sel ? hold_data : core_q;

  sdp_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk     (clk),
    .we      (mem_we),
    .wr_addr (mem_addr),
    .wr_data (mem_data),
    .re      (rd_acc && !hit),
    .rd_addr (rd_addr),
    .q       (core_q)
  );

endmodule

// File: tb/tb_clr_sdp_ram.sv
// Directed scoreboard bench for clr_sdp_ram: a full-depth instance and a DEPTH=200 instance.
module tb_clr_sdp_ram;

  localparam logic [16:0] CLR2 = 17'h0ABCD;

  logic        clk;
  logic        rst;
  logic        clr_req;
  logic        busy;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [16:0] wr_data;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [16:0] rd_data;
  logic        rd_valid;
  logic        err;

  logic        clr_req_2;
  logic        busy_2;
  logic        wr_en_2;
  logic [7:0]  wr_addr_2;
  logic [16:0] wr_data_2;
  logic        rd_en_2;
  logic [7:0]  rd_addr_2;
  logic [16:0] rd_data_2;
  logic        rd_valid_2;
  logic        err_2;

  logic [16:0] exp_q [$];
  logic        nxt_valid;
  logic        nxt_err;
  int          checks;
  int          errors;
  int          n;

  clr_sdp_ram dut (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .err      (err)
  );

  clr_sdp_ram #(
    .DATA_W  (17),
    .ADDR_W  (8),
    .DEPTH   (200),
    .CLR_VAL (CLR2)
  ) dut2 (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req_2),
    .busy     (busy_2),
    .wr_en    (wr_en_2),
    .wr_addr  (wr_addr_2),
    .wr_data  (wr_data_2),
    .rd_en    (rd_en_2),
    .rd_addr  (rd_addr_2),
    .rd_data  (rd_data_2),
    .rd_valid (rd_valid_2),
    .err      (err_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: capture what this edge should produce, then compare at the falling edge.
  task automatic tick();
    logic        ev;
    logic        ee;
    logic [16:0] ed;
    @(posedge clk);
    ev = nxt_valid;
    ee = nxt_err;
    nxt_valid = 1'b0;
    nxt_err   = 1'b0;
    @(negedge clk);
    check_output("rd_valid", 32'(rd_valid), 32'(ev));
    check_output("err", 32'(err), 32'(ee));
    if (ev) begin
      ed = exp_q.pop_front();
      check_output("rd_data", 32'(rd_data), 32'(ed));
    end
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    clr_req   = 1'b0;
    wr_en_2   = 1'b0;
    rd_en_2   = 1'b0;
    clr_req_2 = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [16:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic do_read(input logic [7:0] a, input logic [16:0] e);
    rd_en   = 1'b1;
    rd_addr = a;
    exp_q.push_back(e);
    nxt_valid = 1'b1;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 400) begin
      cnt++;
      tick();
    end
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < 256; i++) begin
      do_read(8'(i), 17'h0);
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nxt_valid = 1'b0;
    nxt_err   = 1'b0;
    rst = 1'b1;
    clr_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
    clr_req_2 = 1'b0; wr_en_2 = 1'b0; wr_addr_2 = '0; wr_data_2 = '0; rd_en_2 = 1'b0; rd_addr_2 = '0;

    // Reset held for two cycles.
    tick();
    tick();
    check_output("reset_busy", 32'(busy), 32'd1);
    check_output("reset_rd_data", 32'(rd_data), 32'd0);
    check_output("reset_busy2", 32'(busy_2), 32'd1);
    rst = 1'b0;

    count_busy(n);
    check_output("clear_len_after_reset", 32'(n), 32'd256);
    check_output("busy_low", 32'(busy), 32'd0);
    check_output("busy2_low", 32'(busy_2), 32'd0);
    read_all_zero();

    // Write then read back, and the held value afterwards.
    do_write(8'h05, 17'h1ABCD);
    tick();
    do_read(8'h05, 17'h1ABCD);
    tick();
    tick();
    check_output("hold_after_read", 32'(rd_data), 32'h1ABCD);

    // Same-address write and read in one cycle.
    do_write(8'h10, 17'h00042);
    do_read(8'h10, 17'h00042);
    tick();
    do_read(8'h10, 17'h00042);
    tick();
    do_read(8'h05, 17'h1ABCD);
    tick();

    // Fill, clear with a concurrent write, and poke the ports while busy.
    for (int i = 0; i < 4; i++) begin
      do_write(8'(i), 17'(17'h10000 + i));
      tick();
    end
    do_read(8'h02, 17'h10002);
    tick();
    do_write(8'h20, 17'h15555);
    clr_req = 1'b1;
    tick();
    check_output("busy_after_clr_req", 32'(busy), 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      if (n == 3) begin
        wr_en = 1'b1; wr_addr = 8'h30; wr_data = 17'h1FFFF; nxt_err = 1'b1;
      end
      if (n == 4) begin
        rd_en = 1'b1; rd_addr = 8'h02; nxt_err = 1'b1;
      end
      if (n == 50) clr_req = 1'b1;
      if (n == 200) begin
        wr_en = 1'b1; wr_addr = 8'h05; wr_data = 17'h1FFFF; nxt_err = 1'b1;
      end
      n++;
      tick();
    end
    check_output("clear_len_clr_req", 32'(n), 32'd256);
    read_all_zero();

    // Out-of-range accesses on the DEPTH=200 instance.
    wr_en_2 = 1'b1; wr_addr_2 = 8'd210; wr_data_2 = 17'h01234;
    tick();
    check_output("oor_write_err", 32'(err_2), 32'd1);
    check_output("oor_write_no_valid", 32'(rd_valid_2), 32'd0);
    rd_en_2 = 1'b1; rd_addr_2 = 8'd210;
    tick();
    check_output("oor_read_err", 32'(err_2), 32'd1);
    check_output("oor_read_valid", 32'(rd_valid_2), 32'd1);
    check_output("oor_read_data", 32'(rd_data_2), 32'(CLR2));
    rd_en_2 = 1'b1; rd_addr_2 = 8'd199;
    tick();
    check_output("edge_read_err", 32'(err_2), 32'd0);
    check_output("edge_read_valid", 32'(rd_valid_2), 32'd1);
    check_output("edge_read_clrval", 32'(rd_data_2), 32'(CLR2));
    wr_en_2 = 1'b1; wr_addr_2 = 8'd199; wr_data_2 = 17'h00777;
    tick();
    check_output("edge_write_err", 32'(err_2), 32'd0);
    rd_en_2 = 1'b1; rd_addr_2 = 8'd199;
    tick();
    check_output("edge_readback", 32'(rd_data_2), 32'h00777);
    tick();
    check_output("dut2_idle_valid", 32'(rd_valid_2), 32'd0);
    check_output("dut2_idle_err", 32'(err_2), 32'd0);

    // Reset in the middle of a clear restarts it from the beginning.
    do_write(8'h07, 17'h1AAAA);
    tick();
    clr_req = 1'b1;
    tick();
    for (int k = 0; k < 99; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy(n);
    check_output("clear_len_after_midreset", 32'(n), 32'd256);
    read_all_zero();

    // Reset coinciding with an idle read suppresses the read.
    do_write(8'h05, 17'h1CCCC);
    tick();
    rd_en = 1'b1; rd_addr = 8'h05; rst = 1'b1;
    tick();
    check_output("rst_read_data", 32'(rd_data), 32'd0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
